stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 133 +++++++++++++
 tb/tb_stage_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Multi-stage instruction sequencer: one-hot stage strobes, a data-memory handshake
// at MEM_STAGE, a retire counter and halt/restart control. Optional memory-wait
// timeout is built when STAGE_TIMEOUT_EN is defined.
module stage_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int MEM_STAGE  = 2,
  parameter int CNT_W      = 32,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  halt,
  input  logic                  mem_op,
  input  logic                  mem_ack,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [2:0]            stage_idx,
  output logic                  mem_req,
  output logic                  retire,
  output logic [CNT_W-1:0]      retire_cnt,
  output logic                  busy,
  output logic                  halted,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_e;

  localparam logic [2:0]            LAST_IDX = 3'(NUM_STAGES - 1);
  localparam logic [2:0]            MEM_IDX  = 3'(MEM_STAGE);
  localparam logic [NUM_STAGES-1:0] EN_ONE   = NUM_STAGES'(1);

  if (NUM_STAGES < 2 || NUM_STAGES > 8 || MEM_STAGE < 0 || MEM_STAGE >= NUM_STAGES ||
      CNT_W < 1 || MAX_WAIT < 1) begin : g_param_check
    $error("stage_sequencer: illegal parameter combination");
  end

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_mem, fire, timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        // start is deliberately ignored here; only a retiring halt leaves RUN
        if (fire) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 3'd1;
        if (retire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (halt) state_d = S_HALTED;
        end
        if (timeout) idx_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pending memory request overrides stall so the handshake is never broken
  always_comb begin
    at_mem   = 1'b0;
    fire     = 1'b0;
    mem_req  = 1'b0;
    stage_en = '0;
    retire   = 1'b0;
    if (state_q == S_RUN) begin
      at_mem  = (idx_q == MEM_IDX) && mem_op;
      mem_req = at_mem;
      fire    = at_mem ? mem_ack : !stall;
      if (fire) stage_en = EN_ONE << idx_q;
      retire  = fire && (idx_q == LAST_IDX);
    end
  end

  assign stage_idx  = idx_q;
  assign retire_cnt = cnt_q;
  assign busy       = (state_q == S_RUN);
  assign halted     = (state_q == S_HALTED);

`ifdef STAGE_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic              waiting;

  // Timeout fires in the MAX_WAIT-th unacknowledged cycle; the stage resets next edge
  assign waiting = mem_req && !mem_ack;
  assign timeout = waiting && (wait_q == WAIT_W'(MAX_WAIT - 1));

  always_comb begin
    wait_d = '0;
    if (waiting && !timeout) wait_d = wait_q + WAIT_W'(1);
    err_d = err_q | timeout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: vector table plus hand-written
// sequences for wrap, asynchronous reset and memory-wait behaviour.
module tb_stage_sequencer;

  typedef struct packed {
    logic st, sl, h, mo, ma;
  } in_t;

  typedef struct packed {
    logic [3:0] en;
    logic [2:0] idx;
    logic       req, ret, busy, hl, err;
    logic [3:0] cnt;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stall = 1'b0, halt = 1'b0, mem_op = 1'b0, mem_ack = 1'b0;
  logic [3:0] stage_en;
  logic [2:0] stage_idx;
  logic       mem_req, retire, busy, halted, err;
  logic [3:0] retire_cnt;

  int   checks = 0;
  int   errors = 0;
  out_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  stage_sequencer #(
    .NUM_STAGES(4),
    .MEM_STAGE (2),
    .CNT_W     (4),
    .MAX_WAIT  (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stall     (stall),
    .halt      (halt),
    .mem_op    (mem_op),
    .mem_ack   (mem_ack),
    .stage_en  (stage_en),
    .stage_idx (stage_idx),
    .mem_req   (mem_req),
    .retire    (retire),
    .retire_cnt(retire_cnt),
    .busy      (busy),
    .halted    (halted),
    .err       (err)
  );

  function automatic in_t mi(input logic st, sl, h, mo, ma);
    in_t r;
    r.st = st; r.sl = sl; r.h = h; r.mo = mo; r.ma = ma;
    return r;
  endfunction

  function automatic out_t mo_(input logic [3:0] en, input int idx, input logic req, ret,
                               busy_, hl, er, input int cnt);
    out_t r;
    r.en = en; r.idx = 3'(idx); r.req = req; r.ret = ret;
    r.busy = busy_; r.hl = hl; r.err = er; r.cnt = 4'(cnt);
    return r;
  endfunction

  function automatic vec_t v(input logic st, sl, h, mo, ma, input logic [3:0] en, input int idx,
                             input logic req, ret, busy_, hl, input int cnt);
    vec_t r;
    r.i = mi(st, sl, h, mo, ma);
    r.o = mo_(en, idx, req, ret, busy_, hl, 1'b0, cnt);
    return r;
  endfunction

  function automatic out_t sample();
    return mo_(stage_en, int'(stage_idx), mem_req, retire, busy, halted, err, int'(retire_cnt));
  endfunction

  task automatic check(input string name, input out_t got, input out_t e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s got en=%b idx=%0d req=%b ret=%b busy=%b halted=%b err=%b cnt=%0d want en=%b idx=%0d req=%b ret=%b busy=%b halted=%b err=%b cnt=%0d",
               name, got.en, got.idx, got.req, got.ret, got.busy, got.hl, got.err, got.cnt,
               e.en, e.idx, e.req, e.ret, e.busy, e.hl, e.err, e.cnt);
    end
  endtask

  task automatic step(input string name, input in_t i, input out_t e);
    @(posedge clk);
    #1;
    start = i.st; stall = i.sl; halt = i.h; mem_op = i.mo; mem_ack = i.ma;
    exp_q.push_back(e);
    @(negedge clk);
    check(name, sample(), exp_q.pop_front());
  endtask

  task automatic do_reset(input string name);
    start = 1'b0; stall = 1'b0; halt = 1'b0; mem_op = 1'b0; mem_ack = 1'b0;
    rst = 1'b0;
    #2;
    check(name, sample(), mo_(4'b0000, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    //      st sl h mo ma  en      idx req ret busy hl cnt
    tbl.push_back(v(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 4'b0010, 1, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 4'b0100, 2, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 4'b1000, 3, 0, 1, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 4'b0001, 0, 0, 0, 1, 0, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 4'b0010, 1, 0, 0, 1, 0, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 4'b0000, 2, 1, 0, 1, 0, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 4'b0000, 2, 1, 0, 1, 0, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 4'b0000, 2, 1, 0, 1, 0, 1));
    tbl.push_back(v(0, 0, 0, 1, 1, 4'b0100, 2, 1, 0, 1, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 4'b1000, 3, 0, 1, 1, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 1, 0, 2));
    tbl.push_back(v(0, 1, 0, 0, 0, 4'b0000, 1, 0, 0, 1, 0, 2));
    tbl.push_back(v(0, 1, 0, 0, 0, 4'b0000, 1, 0, 0, 1, 0, 2));
    tbl.push_back(v(0, 0, 0, 0, 0, 4'b0010, 1, 0, 0, 1, 0, 2));
    tbl.push_back(v(0, 1, 0, 1, 0, 4'b0000, 2, 1, 0, 1, 0, 2));
    tbl.push_back(v(0, 1, 0, 1, 1, 4'b0100, 2, 1, 0, 1, 0, 2));
    tbl.push_back(v(0, 1, 0, 0, 0, 4'b0000, 3, 0, 0, 1, 0, 2));
    tbl.push_back(v(0, 1, 1, 0, 0, 4'b0000, 3, 0, 0, 1, 0, 2));
    tbl.push_back(v(0, 0, 0, 0, 0, 4'b1000, 3, 0, 1, 1, 0, 2));
    tbl.push_back(v(0, 0, 1, 0, 0, 4'b0001, 0, 0, 0, 1, 0, 3));
    tbl.push_back(v(0, 0, 0, 0, 0, 4'b0010, 1, 0, 0, 1, 0, 3));
    tbl.push_back(v(0, 0, 0, 0, 0, 4'b0100, 2, 0, 0, 1, 0, 3));
    tbl.push_back(v(1, 0, 1, 0, 0, 4'b1000, 3, 0, 1, 1, 0, 3));
    tbl.push_back(v(0, 0, 0, 1, 1, 4'b0000, 0, 0, 0, 0, 1, 4));
    tbl.push_back(v(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1, 4));
    tbl.push_back(v(0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 1, 0, 4));
    tbl.push_back(v(0, 0, 0, 0, 1, 4'b0010, 1, 0, 0, 1, 0, 4));
    tbl.push_back(v(0, 0, 0, 1, 0, 4'b0000, 2, 1, 0, 1, 0, 4));

    #1;
    do_reset("reset_state");

    foreach (tbl[n]) step($sformatf("vec%0d", n), tbl[n].i, tbl[n].o);

    // asynchronous reset in the middle of a pending memory request
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_mid_req", sample(), mo_(4'b0000, 0, 0, 0, 0, 0, 0, 0));
    start = 1'b0; mem_op = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // sixteen back-to-back retires wrap the 4-bit counter
    step("wrap_start", mi(1, 0, 0, 0, 0), mo_(4'b0000, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 64; k++) begin
      logic [3:0] en;
      en = 4'b0001 << (k % 4);
      step($sformatf("wrap%0d", k), mi(0, 0, 0, 0, 0),
           mo_(en, k % 4, 0, (k % 4) == 3, 1, 0, 0, (k / 4) % 16));
    end
    step("wrap_done", mi(0, 0, 0, 0, 0), mo_(4'b0001, 0, 0, 0, 1, 0, 0, 0));

    do_reset("reset_before_wait");
    step("wait_start", mi(1, 0, 0, 0, 0), mo_(4'b0000, 0, 0, 0, 0, 0, 0, 0));
`ifdef STAGE_TIMEOUT_EN
    for (int k = 0; k < 19; k++) begin
      out_t e;
      if (k == 0)       e = mo_(4'b0001, 0, 0, 0, 1, 0, 0, 0);
      else if (k == 1)  e = mo_(4'b0010, 1, 0, 0, 1, 0, 0, 0);
      else if (k <= 16) e = mo_(4'b0000, 2, 1, 0, 1, 0, 0, 0);
      else if (k == 17) e = mo_(4'b0001, 0, 0, 0, 1, 0, 1, 0);
      else              e = mo_(4'b0010, 1, 0, 0, 1, 0, 1, 0);
      step($sformatf("timeout%0d", k), mi(0, 0, 0, 1, 0), e);
    end
`else
    for (int k = 0; k < 24; k++) begin
      out_t e;
      logic ack;
      ack = (k == 22);
      if (k == 0)       e = mo_(4'b0001, 0, 0, 0, 1, 0, 0, 0);
      else if (k == 1)  e = mo_(4'b0010, 1, 0, 0, 1, 0, 0, 0);
      else if (k <= 21) e = mo_(4'b0000, 2, 1, 0, 1, 0, 0, 0);
      else if (k == 22) e = mo_(4'b0100, 2, 1, 0, 1, 0, 0, 0);
      else              e = mo_(4'b1000, 3, 0, 1, 1, 0, 0, 0);
      step($sformatf("longwait%0d", k), mi(0, 0, 0, k != 23, ack), e);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
